// File: rtl/ram_tdp_be.sv
// True dual-port RAM with byte write enables, per-port write modes, optional output
// register, same-address collision resolution and a post-reset clear sequence.
module ram_tdp_be #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_DEPTH     = 1024,
    parameter string       MODEA          = "NO_CHANGE",
    parameter string       MODEB          = "NO_CHANGE",
    parameter bit          OUT_REG        = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter string       RAM_STYLE_VAL  = "block",
    localparam int unsigned NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [NUM_BYTES-1:0]  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  douta_valid,
    input  logic                  enb,
    input  logic [NUM_BYTES-1:0]  web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  doutb_valid,
    output logic                  init_busy,
    output logic                  collision
);

    localparam int unsigned MEM_AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam bit A_WF = (MODEA == "WRITE_FIRST");
    localparam bit A_RF = (MODEA == "READ_FIRST");
    localparam bit B_WF = (MODEB == "WRITE_FIRST");
    localparam bit B_RF = (MODEB == "READ_FIRST");

    // Elaboration-time sanity of the parameter set
    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || BYTE_WIDTH == 0
        || 64'(DATA_DEPTH) > (64'(1) << ADDR_WIDTH)
        || !(A_WF || A_RF || MODEA == "NO_CHANGE")
        || !(B_WF || B_RF || MODEB == "NO_CHANGE")
        || RAM_STYLE_VAL == "") begin : g_bad_params
        $error("ram_tdp_be: illegal parameter combination");
    end

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [MEM_AW-1:0]     clr_addr;

    (* ram_style = RAM_STYLE_VAL *)
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic [DATA_WIDTH-1:0] dout_a1, dout_b1;
    logic                  valid_a1, valid_b1;

    logic                  acc_a, wr_a, inr_a, ld_a;
    logic                  acc_b, wr_b, inr_b, ld_b;
    logic                  coll_hit;
    logic [DATA_WIDTH-1:0] old_a, mrg_a, nxt_a;
    logic [DATA_WIDTH-1:0] old_b, mrg_b, nxt_b;

    // Per-port access decode and read-data selection from the pre-write word
    always_comb begin
        acc_a = ena && (state == READY);
        acc_b = enb && (state == READY);
        wr_a  = acc_a && (|wea);
        wr_b  = acc_b && (|web);
        inr_a = 32'(addra) < DATA_DEPTH;
        inr_b = 32'(addrb) < DATA_DEPTH;
        old_a = inr_a ? mem[MEM_AW'(addra)] : '0;
        old_b = inr_b ? mem[MEM_AW'(addrb)] : '0;
        mrg_a = old_a;
        mrg_b = old_b;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (wea[i]) mrg_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (web[i]) mrg_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        ld_a     = acc_a && (!wr_a || A_WF || A_RF);
        ld_b     = acc_b && (!wr_b || B_WF || B_RF);
        nxt_a    = (wr_a && A_WF) ? mrg_a : old_a;
        nxt_b    = (wr_b && B_WF) ? mrg_b : old_b;
        coll_hit = acc_a && acc_b && inr_a && inr_b && (addra == addrb) && (wr_a || wr_b);
    end

    // Clear FSM, memory writes and first output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (CLEAR_ON_RESET) state <= CLEAR;
            else                state <= READY;
            init_busy <= CLEAR_ON_RESET;
            clr_addr  <= '0;
            dout_a1   <= '0;
            dout_b1   <= '0;
            valid_a1  <= 1'b0;
            valid_b1  <= 1'b0;
            collision <= 1'b0;
        end else begin
            valid_a1  <= ld_a;
            valid_b1  <= ld_b;
            collision <= coll_hit;
            if (ld_a) dout_a1 <= nxt_a;
            if (ld_b) dout_b1 <= nxt_b;
            if (state == CLEAR) begin
                mem[clr_addr] <= '0;
                clr_addr      <= clr_addr + MEM_AW'(1);
                if (clr_addr == MEM_AW'(DATA_DEPTH - 1)) begin
                    state     <= READY;
                    init_busy <= 1'b0;
                end
            end else begin
                // Port A lands last so its bytes win when both ports write one address
                for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                    if (wr_b && inr_b && web[i])
                        mem[MEM_AW'(addrb)][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                    if (wr_a && inr_a && wea[i])
                        mem[MEM_AW'(addra)][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    if (OUT_REG) begin : g_oreg
        logic [DATA_WIDTH-1:0] dout_a2, dout_b2;
        logic                  valid_a2, valid_b2;

        // Optional second output stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_a2  <= '0;
                dout_b2  <= '0;
                valid_a2 <= 1'b0;
                valid_b2 <= 1'b0;
            end else begin
                dout_a2  <= dout_a1;
                dout_b2  <= dout_b1;
                valid_a2 <= valid_a1;
                valid_b2 <= valid_b1;
            end
        end

        assign douta       = dout_a2;
        assign doutb       = dout_b2;
        assign douta_valid = valid_a2;
        assign doutb_valid = valid_b2;
    end else begin : g_noreg
        assign douta       = dout_a1;
        assign doutb       = dout_b1;
        assign douta_valid = valid_a1;
        assign doutb_valid = valid_b1;
    end

endmodule

// File: tb/tb_ram_tdp_be.sv
// Directed bench for ram_tdp_be: two instances share stimulus, one latency-1 with
// WRITE_FIRST/READ_FIRST ports, one latency-2 with NO_CHANGE ports.
module tb_ram_tdp_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena, enb;
    logic [3:0]  wea, web;
    logic [4:0]  addra, addrb;
    logic [31:0] dina, dinb;

    logic [31:0] douta, doutb, douta2, doutb2;
    logic        douta_valid, doutb_valid, douta2_valid, doutb2_valid;
    logic        init_busy, init_busy2, collision, collision2;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    ram_tdp_be #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5), .DATA_DEPTH(16),
        .MODEA("WRITE_FIRST"), .MODEB("READ_FIRST"),
        .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1), .RAM_STYLE_VAL("block")
    ) dut (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta), .douta_valid(douta_valid),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
        .doutb(doutb), .doutb_valid(doutb_valid),
        .init_busy(init_busy), .collision(collision)
    );

    ram_tdp_be #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(5), .DATA_DEPTH(16),
        .MODEA("NO_CHANGE"), .MODEB("NO_CHANGE"),
        .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1), .RAM_STYLE_VAL("block")
    ) dut2 (
        .clk(clk), .rst(rst),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta2), .douta_valid(douta2_valid),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
        .doutb(doutb2), .doutb_valid(doutb2_valid),
        .init_busy(init_busy2), .collision(collision2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ena = 1'b1; wea = 4'hF; addra = 5'd1; dina = 32'h1234_5678;
        enb = 1'b1; web = 4'h0; addrb = 5'd1; dinb = 32'h0;
        tick(); tick();
        tests_run++;
        if (douta !== 32'h0 || douta_valid !== 1'b0 || doutb !== 32'h0 || doutb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: douta=%h va=%b doutb=%h vb=%b expected 0", douta, douta_valid, doutb, doutb_valid);
        end
        tests_run++;
        if (init_busy !== 1'b1 || collision !== 1'b0 || douta2 !== 32'h0 || douta2_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: init_busy=%b collision=%b douta2=%h va2=%b expected 1/0/0/0", init_busy, collision, douta2, douta2_valid);
        end
    endtask

    task automatic test_clear();
        int  cnt;
        logic seen_valid;
        cnt = 0; seen_valid = 1'b0;
        ena = 1'b1; wea = 4'hF; addra = 5'd3; dina = 32'hDEAD_BEEF;
        enb = 1'b1; web = 4'h0; addrb = 5'd3;
        rst = 1'b0;
        while (init_busy && cnt < 40) begin
            tick();
            cnt++;
            seen_valid = seen_valid | douta_valid | doutb_valid | collision;
        end
        ena = 1'b1; wea = 4'h0; addra = 5'd3; enb = 1'b0;
        tests_run++;
        if (cnt !== 16) begin
            failures++;
            $display("FAIL clear_length: busy cycles %0d expected 16", cnt);
        end
        tests_run++;
        if (seen_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_ignores_ports: activity seen %b expected 0", seen_valid);
        end
        tick();
        tests_run++;
        if (douta !== 32'h0 || douta_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_access_after_clear: douta=%h va=%b expected 00000000/1", douta, douta_valid);
        end
        ena = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enb = 1'b1; web = 4'h0; addrb = 5'(i);
            tick();
            tests_run++;
            if (doutb !== 32'h0 || doutb_valid !== 1'b1) begin
                failures++;
                $display("FAIL clear_read[%0d]: doutb=%h vb=%b expected 00000000/1", i, doutb, doutb_valid);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_byte_write();
        ena = 1'b1; wea = 4'hF; addra = 5'd5; dina = 32'hAABB_CCDD;
        tick();
        wea = 4'b0101; dina = 32'h1122_3344;
        tick();
        tests_run++;
        if (douta !== 32'hAABB_CC44 && douta !== 32'hAA22_CC44) begin
            failures++;
            $display("FAIL write_first_merge: douta=%h expected AA22CC44", douta);
        end
        wea = 4'h0;
        tick();
        tests_run++;
        if (douta !== 32'hAA22_CC44 || douta_valid !== 1'b1) begin
            failures++;
            $display("FAIL byte_write_read_lat1: douta=%h va=%b expected AA22CC44/1", douta, douta_valid);
        end
        idle();
        tick();
        tests_run++;
        if (douta2 !== 32'hAA22_CC44 || douta2_valid !== 1'b1) begin
            failures++;
            $display("FAIL byte_write_read_lat2: douta2=%h va2=%b expected AA22CC44/1", douta2, douta2_valid);
        end
        tick();
    endtask

    task automatic test_modes();
        ena = 1'b1; wea = 4'hF; addra = 5'd3; dina = 32'h1234_5678;
        tick();
        idle();
        enb = 1'b1; web = 4'h0; addrb = 5'd3;
        tick();
        tests_run++;
        if (doutb !== 32'h1234_5678) begin
            failures++;
            $display("FAIL mode_preload_read: doutb=%h expected 12345678", doutb);
        end
        idle();
        ena = 1'b1; wea = 4'hF; addra = 5'd3; dina = 32'hCAFE_F00D;
        tick();
        tests_run++;
        if (douta !== 32'hCAFE_F00D || douta_valid !== 1'b1) begin
            failures++;
            $display("FAIL write_first: douta=%h va=%b expected CAFEF00D/1", douta, douta_valid);
        end
        idle();
        enb = 1'b1; web = 4'hF; addrb = 5'd3; dinb = 32'h0BAD_BEEF;
        tick();
        tests_run++;
        if (doutb !== 32'hCAFE_F00D || doutb_valid !== 1'b1) begin
            failures++;
            $display("FAIL read_first: doutb=%h vb=%b expected CAFEF00D/1", doutb, doutb_valid);
        end
        tests_run++;
        if (douta2 !== 32'hAA22_CC44 || douta2_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_change_a: douta2=%h va2=%b expected AA22CC44/0", douta2, douta2_valid);
        end
        idle();
        tick();
        tests_run++;
        if (doutb2 !== 32'h1234_5678 || doutb2_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_change_b: doutb2=%h vb2=%b expected 12345678/0", doutb2, doutb2_valid);
        end
        tick();
    endtask

    task automatic test_collision_ww();
        ena = 1'b1; wea = 4'b0011; addra = 5'd7; dina = 32'h0000_00AA;
        enb = 1'b1; web = 4'b1111; addrb = 5'd7; dinb = 32'h1122_3344;
        tick();
        idle();
        tests_run++;
        if (collision !== 1'b1) begin
            failures++;
            $display("FAIL ww_collision_pulse: collision=%b expected 1", collision);
        end
        tests_run++;
        if (douta !== 32'h0000_00AA || doutb !== 32'h0) begin
            failures++;
            $display("FAIL ww_dout_modes: douta=%h doutb=%h expected 000000AA/00000000", douta, doutb);
        end
        tick();
        tests_run++;
        if (collision !== 1'b0) begin
            failures++;
            $display("FAIL ww_collision_width: collision=%b expected 0", collision);
        end
        ena = 1'b1; wea = 4'h0; addra = 5'd7;
        tick();
        idle();
        tests_run++;
        if (douta !== 32'h1122_00AA) begin
            failures++;
            $display("FAIL ww_merge: douta=%h expected 112200AA", douta);
        end
        tick();
    endtask

    task automatic test_collision_wr();
        ena = 1'b1; wea = 4'hF; addra = 5'd9; dina = 32'h1;
        tick();
        dina = 32'h2;
        enb = 1'b1; web = 4'h0; addrb = 5'd9;
        tick();
        idle();
        tests_run++;
        if (doutb !== 32'h1 || doutb_valid !== 1'b1 || collision !== 1'b1) begin
            failures++;
            $display("FAIL wr_collision: doutb=%h vb=%b coll=%b expected 00000001/1/1", doutb, doutb_valid, collision);
        end
        tick();
        ena = 1'b1; wea = 4'h0; addra = 5'd9;
        tick();
        idle();
        tests_run++;
        if (douta !== 32'h2 || collision !== 1'b0) begin
            failures++;
            $display("FAIL wr_after: douta=%h coll=%b expected 00000002/0", douta, collision);
        end
        tick();
    endtask

    task automatic test_out_of_range();
        ena = 1'b1; wea = 4'hF; addra = 5'd20; dina = 32'h7777_7777;
        enb = 1'b1; web = 4'h0; addrb = 5'd20;
        tick();
        idle();
        tests_run++;
        if (doutb !== 32'h0 || doutb_valid !== 1'b1 || collision !== 1'b0) begin
            failures++;
            $display("FAIL oor_read: doutb=%h vb=%b coll=%b expected 00000000/1/0", doutb, doutb_valid, collision);
        end
        enb = 1'b1; web = 4'h0; addrb = 5'd4;
        tick();
        idle();
        tests_run++;
        if (doutb !== 32'h0) begin
            failures++;
            $display("FAIL oor_no_alias: doutb=%h expected 00000000", doutb);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  addrs [3];
        logic [31:0] exp   [3];
        addrs[0] = 5'd5; addrs[1] = 5'd3; addrs[2] = 5'd7;
        exp[0] = 32'hAA22_CC44; exp[1] = 32'h0BAD_BEEF; exp[2] = 32'h1122_00AA;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                ena = 1'b1; wea = 4'h0; addra = addrs[k];
            end else begin
                idle();
            end
            tick();
            if (k < 3) begin
                tests_run++;
                if (douta !== exp[k] || douta_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_lat1[%0d]: douta=%h va=%b expected %h/1", k, douta, douta_valid, exp[k]);
                end
            end
            if (k >= 1) begin
                tests_run++;
                if (douta2 !== exp[k-1] || douta2_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_lat2[%0d]: douta2=%h va2=%b expected %h/1", k, douta2, douta2_valid, exp[k-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        ena = 1'b1; wea = 4'hF; addra = 5'd2; dina = 32'h55;
        tick();
        wea = 4'h0;
        tick();
        idle();
        rst = 1'b1;
        #1;
        tests_run++;
        if (douta !== 32'h0 || douta_valid !== 1'b0 || douta2 !== 32'h0 || douta2_valid !== 1'b0 || init_busy !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: douta=%h va=%b douta2=%h va2=%b busy=%b expected 0/0/0/0/1",
                     douta, douta_valid, douta2, douta2_valid, init_busy);
        end
        tick();
        rst = 1'b0;
        ena = 1'b1; wea = 4'h0; addra = 5'd2;
        for (int i = 0; i < 8; i++) tick();
        tests_run++;
        if (init_busy !== 1'b1 || douta_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_clear_busy: busy=%b va=%b expected 1/0", init_busy, douta_valid);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (douta !== 32'h0 || doutb !== 32'h0 || douta2 !== 32'h0 || collision !== 1'b0 || init_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_clear_reset_outputs: douta=%h doutb=%h douta2=%h coll=%b busy=%b expected 0/0/0/0/1",
                     douta, doutb, douta2, collision, init_busy);
        end
        rst = 1'b0;
        cnt = 0;
        while (init_busy && cnt < 40) begin
            tick();
            cnt++;
        end
        tests_run++;
        if (cnt !== 16) begin
            failures++;
            $display("FAIL restart_clear_length: busy cycles %0d expected 16", cnt);
        end
        tick();
        idle();
        tests_run++;
        if (douta !== 32'h0 || douta_valid !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear_zero: douta=%h va=%b expected 00000000/1", douta, douta_valid);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        addra = '0; addrb = '0; dina = '0; dinb = '0;
        test_reset();
        test_clear();
        test_byte_write();
        test_modes();
        test_collision_ww();
        test_collision_wr();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
